// File: rtl/uart_rx_pkg.sv
// uart_pkg: frame constants and receiver state type, shared with the UART transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;  // baud ticks per bit
    localparam int UART_DATA_BITS   = 8;
    localparam int START_SAMPLE_CNT = 7;   // mid-start-bit decision (T8 from detection)
    localparam int BIT_SAMPLE_CNT   = 15;  // bit-centre decision for data/stop bits

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } uart_state_t;

    // 2-of-3 vote used when majority sampling is compiled in
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line; both flops reset to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage resynchronization of the asynchronous line into clk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver on a 16x baud tick enable, centre sampling, framing/overrun reporting,
// output byte register with valid/ack handshake.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting at each decision tick.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk_rx,
    input  logic       i_rxd,
    input  logic       i_rd_ack,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_rx_done,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam logic [3:0] START_CNT = 4'(START_SAMPLE_CNT);
    localparam logic [3:0] BIT_CNT   = 4'(BIT_SAMPLE_CNT);
    localparam logic [2:0] LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic        rxd_s;
    logic        bit_val;
    uart_state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        frame_good, frame_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_rxd),
        .q     (rxd_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Line level seen at the two previous ticks; [0] is the most recent
    logic [1:0] hist;

    // Tick-rate history of the synchronized line for the majority vote
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        hist <= 2'b11;
        else if (i_clk_rx) hist <= {hist[0], rxd_s};
    end

    assign bit_val = maj3(rxd_s, hist[0], hist[1]);
`else
    assign bit_val = rxd_s;
`endif

    // FSM, tick counter, bit index and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic; everything advances only on a baud tick
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        shreg_n    = shreg;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (i_clk_rx) begin
            cnt_n = cnt + 4'd1;
            case (state)
                IDLE: begin
                    if (!rxd_s) state_n = START;
                end
                START: begin
                    if (cnt == START_CNT) begin
                        if (bit_val) begin
                            state_n = IDLE;          // false start
                        end else begin
                            state_n = DATA;
                            idx_n   = '0;
                        end
                    end
                end
                DATA: begin
                    // 4-bit counter wraps at 15, so each bit centre is 16 ticks apart
                    if (cnt == BIT_CNT) begin
                        shreg_n = {bit_val, shreg[7:1]};
                        idx_n   = idx + 3'd1;
                        if (idx == LAST_IDX) state_n = STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a next start bit with no idle gap is caught
                    if (cnt == BIT_CNT) begin
                        if (bit_val) begin
                            frame_good = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            frame_bad  = 1'b1;
                            state_n    = BRK;
                        end
                    end
                end
                BRK: begin
                    // Wait for the line to return high so a held break never restarts a frame
                    if (rxd_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
            if (state_n != state) cnt_n = '0;
        end
    end

    // Output byte register, completion pulses and handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_rx_done    <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_rx_done   <= frame_good | frame_bad;
            o_frame_err <= frame_bad;
            if (frame_good) begin
                o_data       <= shreg;
                o_data_valid <= 1'b1;
                // An ack in the same clk retires the old byte, so no overrun
                if (i_rd_ack)          o_overrun <= 1'b0;
                else if (o_data_valid) o_overrun <= 1'b1;
            end else if (i_rd_ack) begin
                o_data_valid <= 1'b0;
                o_overrun    <= 1'b0;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (default and majority builds).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_clk_rx = 1'b0;
    logic       i_rxd = 1'b1;
    logic       i_rd_ack = 1'b0;
    logic [7:0] o_data;
    logic       o_data_valid, o_rx_done, o_frame_err, o_overrun, o_busy;

    int checks = 0;
    int failures = 0;
    int early = 0;
    logic [7:0] exp_ff;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .i_clk_rx     (i_clk_rx),
        .i_rxd        (i_rxd),
        .i_rd_ack     (i_rd_ack),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One baud tick: set the pin, let it clear the synchronizer, then pulse the tick
    task automatic tick(input logic b, input logic ack);
        @(negedge clk) i_rxd = b;
        @(negedge clk);
        @(negedge clk);
        i_clk_rx = 1'b1;
        i_rd_ack = ack;
        @(negedge clk);
        i_clk_rx = 1'b0;
        i_rd_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0);
    endtask

    task automatic ack_pulse();
        @(negedge clk) i_rd_ack = 1'b1;
        @(negedge clk) i_rd_ack = 1'b0;
    endtask

    // Drive frame ticks T0..last_t; glitch_t forces one low tick, ack_t acks on that tick
    task automatic frame(input logic [7:0] d, input logic stop, input int glitch_t,
                         input int ack_t, input int last_t);
        logic b;
        early = 0;
        for (int t = 0; t <= last_t; t++) begin
            if (t < 16)       b = 1'b0;
            else if (t < 144) b = d[(t - 16) / 16];
            else              b = stop;
            if (t == glitch_t) b = 1'b0;
            tick(b, t == ack_t);
            if (t < 152 && o_rx_done) early++;
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_data_valid, 1'b0);
        chk("rst_done", o_rx_done, 1'b0);
        chk("rst_ferr", o_frame_err, 1'b0);
        chk("rst_ovr", o_overrun, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk) reset = 1'b1;
        idle(2);

        // 0xA5, done at T152
        frame(8'hA5, 1'b1, -1, -1, 152);
        chk("a5_early", 8'(early), 8'd0);
        chk("a5_done", o_rx_done, 1'b1);
        chk("a5_ferr", o_frame_err, 1'b0);
        chk("a5_data", o_data, 8'hA5);
        chk("a5_valid", o_data_valid, 1'b1);
        chk("a5_busy", o_busy, 1'b0);
        idle(7);
        chk("a5_done_pulse", o_rx_done, 1'b0);
        ack_pulse();
        chk("a5_ack_valid", o_data_valid, 1'b0);

        // Glitch: 4 low ticks, rejected at T8
        early = 0;
        for (int t = 0; t <= 8; t++) begin
            tick(t < 4 ? 1'b0 : 1'b1, 1'b0);
            if (t == 0) chk("gl_busy_t0", o_busy, 1'b1);
            if (t == 7) chk("gl_busy_t7", o_busy, 1'b1);
            if (o_rx_done) early++;
        end
        chk("gl_busy_t8", o_busy, 1'b0);
        idle(8);
        chk("gl_no_done", 8'(early), 8'd0);
        chk("gl_busy_after", o_busy, 1'b0);
        chk("gl_valid", o_data_valid, 1'b0);

        // 0x3C with stop 0, then break held low
        frame(8'h3C, 1'b0, -1, -1, 152);
        chk("fe_done", o_rx_done, 1'b1);
        chk("fe_ferr", o_frame_err, 1'b1);
        chk("fe_data", o_data, 8'hA5);
        chk("fe_valid", o_data_valid, 1'b0);
        chk("fe_busy", o_busy, 1'b1);
        for (int k = 0; k < 30; k++) tick(1'b0, 1'b0);
        chk("brk_busy", o_busy, 1'b1);
        chk("brk_done", o_rx_done, 1'b0);
        tick(1'b1, 1'b0);
        chk("brk_exit", o_busy, 1'b0);
        idle(3);
        frame(8'h5A, 1'b1, -1, -1, 152);
        chk("brk_next_done", o_rx_done, 1'b1);
        chk("brk_next_ferr", o_frame_err, 1'b0);
        chk("brk_next_data", o_data, 8'h5A);
        chk("brk_next_valid", o_data_valid, 1'b1);
        chk("brk_next_ovr", o_overrun, 1'b0);
        idle(7);
        ack_pulse();

        // Back-to-back 0x11, 0x22 with no ack
        frame(8'h11, 1'b1, -1, -1, 152);
        chk("b2b_11", o_data, 8'h11);
        idle(7);
        frame(8'h22, 1'b1, -1, -1, 152);
        chk("b2b_early", 8'(early), 8'd0);
        chk("b2b_22", o_data, 8'h22);
        chk("b2b_valid", o_data_valid, 1'b1);
        chk("b2b_ovr", o_overrun, 1'b1);
        idle(7);
        ack_pulse();
        chk("b2b_ack_valid", o_data_valid, 1'b0);
        chk("b2b_ack_ovr", o_overrun, 1'b0);

        // Ack coincident with completion clears overrun, keeps valid
        frame(8'h33, 1'b1, -1, -1, 152);
        idle(7);
        frame(8'h44, 1'b1, -1, -1, 152);
        chk("ovr_44", o_overrun, 1'b1);
        idle(7);
        frame(8'h55, 1'b1, -1, 152, 152);
        chk("coack_data", o_data, 8'h55);
        chk("coack_valid", o_data_valid, 1'b1);
        chk("coack_ovr", o_overrun, 1'b0);
        idle(7);
        ack_pulse();
        chk("ack_valid", o_data_valid, 1'b0);
        ack_pulse();
        chk("ack_idle_valid", o_data_valid, 1'b0);
        chk("ack_idle_data", o_data, 8'h55);

        // Reset during data bit 4
        frame(8'hC3, 1'b1, -1, -1, 90);
        chk("mid_busy", o_busy, 1'b1);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("mr_data", o_data, 8'h00);
        chk("mr_valid", o_data_valid, 1'b0);
        chk("mr_done", o_rx_done, 1'b0);
        chk("mr_ferr", o_frame_err, 1'b0);
        chk("mr_ovr", o_overrun, 1'b0);
        chk("mr_busy", o_busy, 1'b0);
        i_rxd = 1'b1;
        @(negedge clk) reset = 1'b1;
        idle(3);
        frame(8'h5A, 1'b1, -1, -1, 152);
        chk("mr_next_done", o_rx_done, 1'b1);
        chk("mr_next_data", o_data, 8'h5A);
        chk("mr_next_valid", o_data_valid, 1'b1);
        idle(7);
        ack_pulse();

        // 0xFF with a single low tick at bit 3 centre
`ifdef UART_RX_MAJORITY_EN
        exp_ff = 8'hFF;
`else
        exp_ff = 8'hF7;
`endif
        frame(8'hFF, 1'b1, 72, -1, 152);
        chk("glitch_done", o_rx_done, 1'b1);
        chk("glitch_ferr", o_frame_err, 1'b0);
        chk("glitch_data", o_data, exp_ff);
        idle(7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
